truth_table_sweeper: RTL and testbench

Clocked stimulus/capture stage that sits directly upstream of a combinational candidate circuit under evaluation. It drives every input vector 0..2^N_IN-1 onto the candidate in ascending order and waits a programmable settle time for the candidate's gate delays to resolve. It then samples the candidate's output and streams one (index, bit) result per vector to the downstream fitness scorer over a valid/ready handshake. It also accumulates the full truth table for single-shot readout.

---
 rtl/truth_table_sweeper.sv | 134 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a combinational candidate in ascending order, waits a settle
// time, samples the output and streams (index, bit) results while building the truth table.
module truth_table_sweeper #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [N_IN-1:0]          dut_in,
  input  logic                     dut_out,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [N_IN-1:0]          result_index,
  output logic                     result_bit,
  output logic [(2**N_IN)-1:0]     table_out
);

  localparam int              NV       = 32'd1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 32'sd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2,
    FIN    = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [N_IN-1:0]   index_r, index_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [N_IN-1:0]   dut_in_s;
  logic [N_IN-1:0]   result_index_s;
  logic              busy_s, done_s, result_valid_s, result_bit_s;
  logic [NV-1:0]     table_s;

  // Next-state and next-output computation; every register holds unless a state updates it.
  always_comb begin
    state_s        = state_r;
    index_s        = index_r;
    cnt_s          = cnt_r;
    dut_in_s       = dut_in;
    busy_s         = busy;
    done_s         = 1'b0;
    result_valid_s = result_valid;
    result_index_s = result_index;
    result_bit_s   = result_bit;
    table_s        = table_out;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = SETTLE;
          index_s  = {N_IN{1'b0}};
          dut_in_s = {N_IN{1'b0}};
          cnt_s    = {CNT_W{1'b0}};
          table_s  = {NV{1'b0}};
          busy_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        cnt_s = cnt_r + CNT_W'(1);
        // Last settle cycle: the candidate has had SETTLE_CYCLES edges to resolve.
        if (cnt_r == CNT_LAST) begin
          result_bit_s       = dut_out;
          result_index_s     = index_r;
          result_valid_s     = 1'b1;
          table_s[index_r]   = dut_out;
          state_s            = EMIT;
        end else begin
          state_s = SETTLE;
        end
      end
      EMIT: begin
        if (result_valid && result_ready) begin
          result_valid_s = 1'b0;
          if (index_r == LAST_IDX) begin
            state_s = FIN;
            done_s  = 1'b1;
          end else begin
            index_s  = index_r + N_IN'(1);
            dut_in_s = index_r + N_IN'(1);
            cnt_s    = {CNT_W{1'b0}};
            state_s  = SETTLE;
          end
        end else begin
          state_s = EMIT;
        end
      end
      FIN: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        state_s        = IDLE;
        busy_s         = 1'b0;
        result_valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset wipes everything including a partial table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      index_r      <= {N_IN{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      dut_in       <= {N_IN{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result_index <= {N_IN{1'b0}};
      result_bit   <= 1'b0;
      table_out    <= {NV{1'b0}};
    end else begin
      state_r      <= state_s;
      index_r      <= index_s;
      cnt_r        <= cnt_s;
      dut_in       <= dut_in_s;
      busy         <= busy_s;
      done         <= done_s;
      result_valid <= result_valid_s;
      result_index <= result_index_s;
      result_bit   <= result_bit_s;
      table_out    <= table_s;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Three sweepers (AND2/S=8, OR2/S=1, XOR3/S=3) share stimulus; a transaction-timeline model
// predicts every output each cycle, and literal checks pin the model to known truth tables.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic chk_en = 1'b0;

  always #10 clk = ~clk;

  logic [1:0] din_a, ridx_a;
  logic [3:0] tbl_a;
  logic       out_a;
  logic [1:0] din_b, ridx_b;
  logic [3:0] tbl_b;
  logic       out_b;
  logic [2:0] din_c, ridx_c;
  logic [7:0] tbl_c;
  logic       out_c;
  logic [2:0] busy_v, done_v, valid_v, rbit_v;

  assign #50 out_a = din_a[1] & din_a[0];
  assign #5  out_b = din_b[1] | din_b[0];
  assign #50 out_c = din_c[2] ^ din_c[1] ^ din_c[0];

  truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(8), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .start(start), .busy(busy_v[0]), .done(done_v[0]),
    .dut_in(din_a), .dut_out(out_a), .result_valid(valid_v[0]), .result_ready(ready),
    .result_index(ridx_a), .result_bit(rbit_v[0]), .table_out(tbl_a));

  truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(1), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .start(start), .busy(busy_v[1]), .done(done_v[1]),
    .dut_in(din_b), .dut_out(out_b), .result_valid(valid_v[1]), .result_ready(ready),
    .result_index(ridx_b), .result_bit(rbit_v[1]), .table_out(tbl_b));

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(3), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .start(start), .busy(busy_v[2]), .done(done_v[2]),
    .dut_in(din_c), .dut_out(out_c), .result_valid(valid_v[2]), .result_ready(ready),
    .result_index(ridx_c), .result_bit(rbit_v[2]), .table_out(tbl_c));

  logic [2:0] din_v [3];
  logic [2:0] ridx_v [3];
  logic [7:0] tbl_v [3];
  assign din_v[0]  = {1'b0, din_a};
  assign din_v[1]  = {1'b0, din_b};
  assign din_v[2]  = din_c;
  assign ridx_v[0] = {1'b0, ridx_a};
  assign ridx_v[1] = {1'b0, ridx_b};
  assign ridx_v[2] = ridx_c;
  assign tbl_v[0]  = {4'd0, tbl_a};
  assign tbl_v[1]  = {4'd0, tbl_b};
  assign tbl_v[2]  = tbl_c;

  // Model: a vector is driven, its result appears SETTLE edges later, and the next vector
  // is driven on the edge that completes the handshake.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       valid;
    logic [3:0] v;
    logic [7:0] t;
    logic [2:0] din;
    logic [2:0] ridx;
    logic       rbit;
    logic [7:0] tbl;
  } mdl_t;

  mdl_t m [3];
  int   ncmp = 0;
  int   nfail = 0;
  int   vec_cnt = 0;
  int   done_a_cnt = 0;
  logic [7:0] res_a [$];

  function automatic int nvec(input int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic int setl(input int k);
    case (k)
      0:       return 8;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic cand(input int k, input int v);
    logic [2:0] b;
    b = v[2:0];
    case (k)
      0:       return (v == 3);
      1:       return (v != 0);
      default: return b[2] ^ b[1] ^ b[0];
    endcase
  endfunction

  function automatic mdl_t step(input mdl_t s, input int k, input logic st, input logic rdy);
    mdl_t r;
    r = s;
    r.done = 1'b0;
    if (s.done) begin
      r.busy = 1'b0;
    end else if (!s.busy) begin
      if (st) begin
        r.busy = 1'b1; r.v = 4'd0; r.t = 8'd0; r.din = 3'd0; r.tbl = 8'd0;
      end
    end else if (!s.valid) begin
      r.t = s.t + 8'd1;
      if (int'(r.t) == setl(k)) begin
        r.valid = 1'b1;
        r.ridx  = s.v[2:0];
        r.rbit  = cand(k, int'(s.v));
        r.tbl[s.v] = r.rbit;
      end
    end else if (rdy) begin
      r.valid = 1'b0;
      if (int'(s.v) == nvec(k) - 1) begin
        r.done = 1'b1;
      end else begin
        r.v = s.v + 4'd1;
        r.din = r.v[2:0];
        r.t = 8'd0;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    int add;
    add = 0;
    if (reset) begin
      for (int k = 0; k < 3; k++) m[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m[k].valid && ready) add = add + 1;
        m[k] <= step(m[k], k, start, ready);
      end
      vec_cnt <= vec_cnt + add;
    end
  end

  always @(posedge clk) begin
    if (!reset && valid_v[0] && ready) res_a.push_back({5'd0, ridx_a, rbit_v[0]});
    if (!reset && done_v[0]) done_a_cnt = done_a_cnt + 1;
  end

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("busy",  k, 8'(busy_v[k]),  8'(m[k].busy));
        chk("done",  k, 8'(done_v[k]),  8'(m[k].done));
        chk("valid", k, 8'(valid_v[k]), 8'(m[k].valid));
        chk("dut_in", k, 8'(din_v[k]),  8'(m[k].din));
        chk("r_idx", k, 8'(ridx_v[k]),  8'(m[k].ridx));
        chk("r_bit", k, 8'(rbit_v[k]),  8'(m[k].rbit));
        chk("table", k, tbl_v[k],       m[k].tbl);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_v != 3'd0 || done_v != 3'd0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      ncmp++; nfail++;
      $display("FAIL idle_timeout got busy=%b expected 000", busy_v);
    end
  endtask

  task automatic wait_a(input logic [1:0] idx, input logic want_valid);
    int n;
    n = 0;
    while (!(din_a == idx && valid_v[0] == want_valid && (!want_valid || ridx_a == idx)) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      ncmp++; nfail++;
      $display("FAIL wait_timeout got din=%0d expected %0d", din_a, idx);
    end
  endtask

  task automatic check_res_a();
    logic [7:0] ex [4];
    ex = '{8'd0, 8'd2, 8'd4, 8'd7};
    chk("res_cnt", 0, 8'(res_a.size()), 8'd4);
    for (int i = 0; i < 4; i++)
      if (i < res_a.size()) chk("res_seq", i, res_a[i], ex[i]);
  endtask

  initial begin
    int cyc, cb, cc;
    #3 reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_table", 0, tbl_v[0], 8'h00);
    chk("rst_busy", 0, 8'(busy_v), 8'h00);

    // Ready tied high: fixed cycle counts and known truth tables
    ready = 1'b1;
    res_a.delete();
    pulse_start();
    cyc = 0; cb = 0; cc = 0;
    while (!done_v[0] && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done_v[1] && cb == 0) cb = cyc;
      if (done_v[2] && cc == 0) cc = cyc;
    end
    chk("cycles", 0, 8'(cyc), 8'd36);
    chk("cycles", 1, 8'(cb), 8'd8);
    chk("cycles", 2, 8'(cc), 8'd32);
    wait_idle();
    chk("lit_table", 0, tbl_v[0], 8'b0000_1000);
    chk("lit_table", 1, tbl_v[1], 8'b0000_1110);
    chk("lit_table", 2, tbl_v[2], 8'b1001_0110);
    check_res_a();

    // Backpressure on index 2
    res_a.delete();
    pulse_start();
    wait_a(2'd2, 1'b1);
    ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 0, 8'(valid_v[0]), 8'd1);
      chk("bp_idx", 0, 8'(ridx_a), 8'd2);
      chk("bp_din", 0, 8'(din_a), 8'd2);
    end
    ready = 1'b1;
    wait_idle();
    chk("bp_table", 0, tbl_v[0], 8'b0000_1000);
    check_res_a();

    // Reset during SETTLE of index 1
    pulse_start();
    wait_a(2'd1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 0, 8'(busy_v[0]), 8'd0);
    chk("mid_rst_valid", 0, 8'(valid_v[0]), 8'd0);
    chk("mid_rst_table", 0, tbl_v[0], 8'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    res_a.delete();
    done_a_cnt = 0;
    pulse_start();
    wait_idle();
    chk("post_rst_table", 0, tbl_v[0], 8'b0000_1000);
    chk("post_rst_done", 0, 8'(done_a_cnt), 8'd1);
    check_res_a();

    // Start pulsed again during EMIT
    res_a.delete();
    done_a_cnt = 0;
    pulse_start();
    wait_a(2'd1, 1'b1);
    pulse_start();
    wait_idle();
    repeat (3) @(negedge clk);
    chk("restart_done", 0, 8'(done_a_cnt), 8'd1);
    check_res_a();

    // Random ready, start and occasional reset
    repeat (1500) begin
      @(negedge clk);
      ready = ($urandom_range(3) != 0);
      start = ($urandom_range(7) == 0);
      reset = ($urandom_range(199) == 0);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; ready = 1'b1;
    wait_idle();

    // Start held high: back-to-back sweeps
    start = 1'b1;
    repeat (120) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("final_table", 0, tbl_v[0], 8'b0000_1000);
    chk("final_table", 1, tbl_v[1], 8'b0000_1110);
    chk("final_table", 2, tbl_v[2], 8'b1001_0110);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, nfail);
    $finish;
  end

endmodule
